// File: rtl/interconnect_pkg.sv
// Shared types and constants for the interconnect FIFO drain path.
package interconnect_pkg;

  localparam int unsigned BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain
  } tx_state_e;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry registered buffer (head + skid) with valid/ready on both sides.
module skid_buffer #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] skid_q, skid_d;
  logic [1:0]       occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             push, xfer;

  assign in_ready_o  = (occ_q != 2'd2);
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign occ_o       = occ_q;

  always_comb begin
    push    = in_valid_i && in_ready_o;
    xfer    = valid_q && out_ready_i;
    head_d  = head_q;
    skid_d  = skid_q;
    occ_d   = occ_q;
    unique case ({push, xfer})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_data_i;
        else               skid_d = in_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = skid_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy holds; the older skid word moves up ahead of the new one.
        if (occ_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = skid_q;
          skid_d = in_data_i;
        end
      end
      default: ;
    endcase
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      skid_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fifo_stream_tx.sv
// FIFO drain: pops a show-ahead FIFO into a registered stream, tags bursts, counts them.
module fifo_stream_tx
  import interconnect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   enable_i,
  input  logic [DATA_WIDTH-1:0]  fifo_data_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_pop_o,
  output logic [DATA_WIDTH-1:0]  tx_data_o,
  output logic                   tx_last_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic [BURST_CNT_W-1:0] burst_cnt_o
);

  localparam int unsigned BeatW = cnt_width(BURST_LEN);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);

  tx_state_e              state_q;
  logic [BeatW-1:0]       beat_cnt_q;
  logic [BURST_CNT_W-1:0] burst_cnt_q;

  logic                  buf_ready;
  logic [1:0]            occ;
  logic [DATA_WIDTH:0]   buf_out;
  logic                  pop;

  // Pop never looks at tx_ready_i, keeping the sink's ready off the FIFO pop path.
  assign pop = rstn_i && enable_i && !fifo_empty_i && buf_ready && (state_q != StDrain);

  skid_buffer #(
    .Width(DATA_WIDTH + 1)
  ) u_skid_buffer (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .in_valid_i (pop),
    .in_data_i  ({fifo_data_i, (beat_cnt_q == BeatLast)}),
    .in_ready_o (buf_ready),
    .out_valid_o(tx_valid_o),
    .out_data_o (buf_out),
    .out_ready_i(tx_ready_i),
    .occ_o      (occ)
  );

  assign fifo_pop_o  = pop;
  assign tx_data_o   = buf_out[DATA_WIDTH:1];
  assign tx_last_o   = buf_out[0];
  assign busy_o      = (state_q != StIdle);
  assign burst_cnt_o = burst_cnt_q;

  // Beat alignment survives IDLE/DRAIN; only reset re-aligns bursts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (pop) begin
        beat_cnt_q <= (beat_cnt_q == BeatLast) ? '0 : beat_cnt_q + BeatW'(1);
      end
      if (tx_valid_o && tx_ready_i && tx_last_o) begin
        burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
      end
      case (state_q)
        StIdle: begin
          if (enable_i && !fifo_empty_i) state_q <= StActive;
        end
        StActive: begin
          if (!enable_i)                                       state_q <= StDrain;
          else if (fifo_empty_i && (occ == 2'd0) && !pop)      state_q <= StIdle;
        end
        StDrain: begin
          if (enable_i)               state_q <= StActive;
          else if (occ == 2'd0)       state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
